// File: rtl/cache_pkg.sv
// Shared cache types: line/beat/address widths and the adaptor FSM encoding.
// Imported by the cacheline adaptor and its bench.
package cache_pkg;

    localparam int BEATS       = 4;
    localparam int OFFSET_BITS = 5;

    typedef logic [255:0] line_t;
    typedef logic [63:0]  burst_t;
    typedef logic [31:0]  addr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges a single-transfer cacheline port to a beat-wise burst memory port.
// Lines are moved as BEATS ascending beats; completion is a one-cycle resp.
module cacheline_adaptor
    import cache_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cacheline_read,
    input  logic               cacheline_write,
    input  logic [ADDR_W-1:0]  cacheline_addr,
    input  logic [LINE_W-1:0]  cacheline_wdata,
    output logic [LINE_W-1:0]  cacheline_rdata,
    output logic               cacheline_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [ADDR_W-1:0]  pmem_address,
    output logic [BURST_W-1:0] pmem_wdata,
    input  logic [BURST_W-1:0] pmem_rdata,
    input  logic               pmem_resp
);

    localparam int NBEAT = LINE_W / BURST_W;
    localparam int BW    = $clog2(NBEAT);
    localparam int OFF   = $clog2(LINE_W / 8);

    localparam logic [BW-1:0]     LAST_BEAT  = BW'(NBEAT - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << OFF) - 1);

    adaptor_state_t    state;
    logic [BW-1:0]     beat;
    logic [LINE_W-1:0] wbuf;
    logic [LINE_W-1:0] rline;
    logic [ADDR_W-1:0] addr_r;

    // Burst sequencing: request pickup, beat counting, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cacheline_write) begin
                        state <= WR_BURST;
                        beat  <= '0;
                    end else if (cacheline_read) begin
                        state <= RD_BURST;
                        beat  <= '0;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (pmem_resp) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request capture in IDLE; read beats land in their ascending slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf   <= '0;
            rline  <= '0;
            addr_r <= '0;
        end else begin
            if (state == IDLE) begin
                if (cacheline_write) begin
                    wbuf   <= cacheline_wdata;
                    addr_r <= cacheline_addr & ALIGN_MASK;
                end else if (cacheline_read) begin
                    addr_r <= cacheline_addr & ALIGN_MASK;
                end
            end
            if (state == RD_BURST && pmem_resp)
                rline[beat*BURST_W +: BURST_W] <= pmem_rdata;
        end
    end

    assign pmem_read       = (state == RD_BURST);
    assign pmem_write      = (state == WR_BURST);
    assign cacheline_resp  = (state == DONE);
    assign pmem_address    = addr_r;
    assign pmem_wdata      = wbuf[beat*BURST_W +: BURST_W];
    assign cacheline_rdata = rline;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: scripted memory beats, scoreboard queues
// of expected addresses, write beats and read lines.
module tb_cacheline_adaptor;
    import cache_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   cacheline_read;
    logic   cacheline_write;
    addr_t  cacheline_addr;
    line_t  cacheline_wdata;
    line_t  cacheline_rdata;
    logic   cacheline_resp;
    logic   pmem_read;
    logic   pmem_write;
    addr_t  pmem_address;
    burst_t pmem_wdata;
    burst_t pmem_rdata;
    logic   pmem_resp;

    int errors = 0;
    int checks = 0;

    line_t  rd_q[$];
    burst_t wr_q[$];
    addr_t  addr_q[$];
    line_t  last_rd;

    cacheline_adaptor dut (
        .clk             (clk),
        .rst             (rst),
        .cacheline_read  (cacheline_read),
        .cacheline_write (cacheline_write),
        .cacheline_addr  (cacheline_addr),
        .cacheline_wdata (cacheline_wdata),
        .cacheline_rdata (cacheline_rdata),
        .cacheline_resp  (cacheline_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction in the current (IDLE) cycle, feed beats in
    // cycles b0..b3 and check every cycle up to and past the resp.
    task automatic run_xfer(input bit wr, input bit both, input addr_t a,
                            input line_t l, input int b0, input int b1,
                            input int b2, input int b3, input bit scramble);
        int    bc[4];
        int    done_c;
        int    k;
        bit    got;
        addr_t al;
        bc     = '{b0, b1, b2, b3};
        done_c = b3 + 1;
        al     = {a[31:5], 5'b0};
        cacheline_addr  = a;
        cacheline_wdata = l;
        cacheline_write = wr;
        cacheline_read  = !wr || both;
        addr_q.push_back(al);
        if (wr)
            for (int i = 0; i < 4; i++) wr_q.push_back(l[i*64 +: 64]);
        else
            rd_q.push_back(l);
        k   = 0;
        got = 1'b0;
        for (int c = 1; c <= done_c + 3 && !got; c++) begin
            step();
            pmem_resp  = (k < 4) && (c == bc[k]);
            pmem_rdata = (pmem_resp && !wr) ? l[k*64 +: 64] : '0;
            if (scramble && c == 2) begin
                cacheline_addr  = ~a;
                cacheline_wdata = ~l;
            end
            chk("excl", 256'(pmem_read & pmem_write), 256'(0));
            if (cacheline_resp) begin
                got = 1'b1;
                chk("resp_cyc", 256'(c), 256'(done_c));
                chk("req_off", 256'(pmem_read | pmem_write), 256'(0));
                if (wr) begin
                    chk("rd_keep", cacheline_rdata, last_rd);
                end else begin
                    last_rd = rd_q.pop_front();
                    chk("rdata", cacheline_rdata, last_rd);
                end
                void'(addr_q.pop_front());
                cacheline_read  = 1'b0;
                cacheline_write = 1'b0;
                pmem_resp       = 1'b0;
            end else begin
                if (wr) begin
                    chk("pwrite", 256'(pmem_write), 256'(1));
                    chk("no_pread", 256'(pmem_read), 256'(0));
                end else begin
                    chk("pread", 256'(pmem_read), 256'(1));
                end
                chk("paddr", 256'(pmem_address), 256'(al));
                if (wr && wr_q.size() > 0) begin
                    chk("wdata", 256'(pmem_wdata), 256'(wr_q[0]));
                    if (pmem_resp) void'(wr_q.pop_front());
                end
            end
            if (pmem_resp) k++;
        end
        if (!got) begin
            chk("timeout", 256'(0), 256'(1));
            cacheline_read  = 1'b0;
            cacheline_write = 1'b0;
            pmem_resp       = 1'b0;
            rd_q.delete();
            wr_q.delete();
            addr_q.delete();
        end
        step();
        chk("idle_req", 256'(pmem_read | pmem_write), 256'(0));
        chk("idle_resp", 256'(cacheline_resp), 256'(0));
        chk("idle_addr", 256'(pmem_address), 256'(al));
        chk("idle_rdata", cacheline_rdata, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t l;
        rst             = 1'b1;
        cacheline_read  = 1'b0;
        cacheline_write = 1'b0;
        cacheline_addr  = '0;
        cacheline_wdata = '0;
        pmem_rdata      = '0;
        pmem_resp       = 1'b0;
        last_rd         = '0;
        step();
        step();
        chk("rst_rdata", cacheline_rdata, '0);
        chk("rst_req", 256'(pmem_read | pmem_write), 256'(0));
        chk("rst_resp", 256'(cacheline_resp), 256'(0));
        chk("rst_addr", 256'(pmem_address), 256'(0));
        chk("rst_wdata", 256'(pmem_wdata), 256'(0));
        rst = 1'b0;

        // Read, back-to-back beats.
        l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        run_xfer(1'b0, 1'b0, 32'h0000_1234, l, 1, 2, 3, 4, 1'b0);

        // Write with gap cycles between beats.
        l = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        run_xfer(1'b1, 1'b0, 32'h8000_00E0, l, 2, 3, 6, 9, 1'b0);

        // Dirty victim write-back, then the fill read with no idle gap.
        l = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        run_xfer(1'b1, 1'b0, 32'h0000_4010, l, 1, 2, 3, 4, 1'b0);
        l = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        run_xfer(1'b0, 1'b0, 32'h0000_501F, l, 1, 3, 4, 5, 1'b0);

        // Both requests high: write wins.
        l = {8{32'hC0FF_EE00}};
        run_xfer(1'b1, 1'b1, 32'h0000_0040, l, 1, 2, 4, 5, 1'b0);

        // Inputs change under an active write burst.
        l = {64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_F0F0_F0F0,
             64'h5555_AAAA_5555_AAAA, 64'hFEDC_BA98_7654_3210};
        run_xfer(1'b1, 1'b0, 32'h1234_5660, l, 1, 3, 5, 6, 1'b1);

        // Reset after two read beats aborts the burst.
        cacheline_read = 1'b1;
        cacheline_addr = 32'h0000_0100;
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        pmem_rdata = 64'h1111_2222_3333_4444;
        step();
        chk("pre_rst_pread", 256'(pmem_read), 256'(1));
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
        rst            = 1'b1;
        cacheline_read = 1'b0;
        step();
        chk("abort_req", 256'(pmem_read | pmem_write), 256'(0));
        chk("abort_resp", 256'(cacheline_resp), 256'(0));
        chk("abort_rdata", cacheline_rdata, '0);
        rst     = 1'b0;
        last_rd = '0;
        step();
        chk("abort_resp2", 256'(cacheline_resp), 256'(0));
        chk("abort_idle", 256'(pmem_read | pmem_write), 256'(0));

        l = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        run_xfer(1'b0, 1'b0, 32'hFFFF_FFE7, l, 2, 3, 4, 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
